// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch stage and the decoder.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {instr, pc} entries for decode.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests to instruction memory,
// in-order response capture into a small buffer, redirect and reset squashing.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             DW      = $clog2(2 * DEPTH + 1);
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [DW-1:0] r_drop_cnt;

    logic [31:0]   w_target;
    logic          w_stale;
    logic          w_live;
    logic          w_pop;
    logic [CW:0]   w_used;
    logic [DW-1:0] w_inflight;
    logic          w_buf_full;
    logic          w_buf_empty;
    logic [CW-1:0] w_buf_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_din;
    logic          w_unused_tgt_lsb;

    assign w_target         = {PCTargetE[31:2], 2'b00};
    assign w_unused_tgt_lsb = ^PCTargetE[1:0];

    // A response is stale if it belongs to a squashed request stream; otherwise it is live.
    assign w_stale = imem_rvalid && ((r_drop_cnt != '0) || PCSrcE);
    assign w_live  = imem_rvalid && !w_stale;

    // Decode handshake: the head is consumed when ValidD=1 and StallD=0 on a rising edge;
    // while StallD=1 the head stays stable. A redirect overrides the consume.
    assign w_pop = rst && !w_buf_empty && !StallD && !PCSrcE;

    // Credits count the slot freed by this cycle's consume, giving one fetch per cycle.
    assign w_used   = {1'b0, w_buf_count} + {1'b0, r_outstanding} - {{CW{1'b0}}, w_pop};
    assign imem_req  = rst && !PCSrcE && (w_used < DEPTH_C);
    assign imem_addr = r_fetch_pc;

    // Every request still in flight, both squashed and live, less one retiring now.
    assign w_inflight = r_drop_cnt + DW'(r_outstanding) - DW'(imem_rvalid);

    assign w_din = '{instr: imem_rdata, pc: r_resp_pc};

    fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_buf (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_live),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .i_flush (PCSrcE),
        .o_dout  (w_head),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= w_inflight;
        end else if (PCSrcE) begin
            r_fetch_pc    <= w_target;
            r_resp_pc     <= w_target;
            r_outstanding <= '0;
            r_drop_cnt    <= w_inflight;
        end else begin
            if (imem_req) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_live)   r_resp_pc  <= r_resp_pc + PC_STEP;
            r_outstanding <= r_outstanding + CW'(imem_req) - CW'(w_live);
            if (w_stale)  r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    assign ValidD   = rst && !w_buf_empty;
    assign InstrD   = rst ? w_head.instr : '0;
    assign PCD      = rst ? w_head.pc : '0;
    assign PCPlus4D = rst ? (w_head.pc + PC_STEP) : '0;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(w_live && w_buf_full));
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst)
        {1'b0, r_outstanding} <= DEPTH_C);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences
// for redirect with stale responses and mid-stream reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallD = 1'b0;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    int n_checks = 0;
    int n_errors = 0;

    int          mem_lat = 1;
    int unsigned mem_cyc = 0;
    int unsigned due_q[$];
    logic [31:0] addr_q[$];

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] target;
        logic        exp_valid;
        logic [31:0] exp_pcd;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    fetch_unit #(
        .RESET_PC (32'h00000000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .StallD      (StallD),
        .ValidD      (ValidD),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D)
    );

    // clock / reset
    always #5 clk = ~clk;

    // instruction memory: fixed latency, in order, data = address + 0x100
    always @(posedge clk) begin
        mem_cyc = mem_cyc + 1;
        if (imem_req === 1'b1) begin
            due_q.push_back(mem_cyc + mem_lat - 1);
            addr_q.push_back(imem_addr);
        end
        if (due_q.size() > 0 && due_q[0] == mem_cyc) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= addr_q[0] + 32'h100;
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step(input logic s, input logic p, input logic [31:0] t);
        @(negedge clk);
        rst       = 1'b1;
        StallD    = s;
        PCSrcE    = p;
        PCTargetE = t;
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b0;
            StallD    = 1'b0;
            PCSrcE    = 1'b0;
            PCTargetE = '0;
            #1;
            chk("rst.ValidD", {31'b0, ValidD}, 32'd0);
            chk("rst.imem_req", {31'b0, imem_req}, 32'd0);
            chk("rst.InstrD", InstrD, 32'd0);
            chk("rst.PCD", PCD, 32'd0);
            chk("rst.PCPlus4D", PCPlus4D, 32'd0);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pcd);
        chk({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, v});
        if (v) begin
            chk({tag, ".PCD"}, PCD, pcd);
            chk({tag, ".InstrD"}, InstrD, pcd + 32'h100);
            chk({tag, ".PCPlus4D"}, PCPlus4D, pcd + 32'd4);
        end
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, r});
        if (r) chk({tag, ".imem_addr"}, imem_addr, a);
    endtask

    function automatic vec_t mk(input logic s, input logic p, input logic [31:0] t,
                                input logic v, input logic [31:0] pcd,
                                input logic r, input logic [31:0] a);
        vec_t x;
        x.stall = s; x.pcsrc = p; x.target = t;
        x.exp_valid = v; x.exp_pcd = pcd; x.exp_req = r; x.exp_addr = a;
        return x;
    endfunction

    initial begin
        vec_t vecs[23];
        // streaming from reset, 1-cycle memory
        vecs[0]  = mk(0, 0, 0,            0, 0,            1, 32'h0);
        vecs[1]  = mk(0, 0, 0,            0, 0,            1, 32'h4);
        vecs[2]  = mk(0, 0, 0,            1, 32'h0,        1, 32'h8);
        vecs[3]  = mk(0, 0, 0,            1, 32'h4,        1, 32'hC);
        vecs[4]  = mk(0, 0, 0,            1, 32'h8,        1, 32'h10);
        // five stall cycles: buffer fills, head frozen, no requests
        vecs[5]  = mk(1, 0, 0,            1, 32'hC,        0, 0);
        vecs[6]  = mk(1, 0, 0,            1, 32'hC,        0, 0);
        vecs[7]  = mk(1, 0, 0,            1, 32'hC,        0, 0);
        vecs[8]  = mk(1, 0, 0,            1, 32'hC,        0, 0);
        vecs[9]  = mk(1, 0, 0,            1, 32'hC,        0, 0);
        vecs[10] = mk(0, 0, 0,            1, 32'hC,        1, 32'h14);
        vecs[11] = mk(0, 0, 0,            1, 32'h10,       1, 32'h18);
        vecs[12] = mk(0, 0, 0,            1, 32'h14,       1, 32'h1C);
        // redirect with a response arriving and StallD=1; low target bits ignored
        vecs[13] = mk(1, 1, 32'h303,      1, 32'h18,       0, 0);
        vecs[14] = mk(0, 0, 0,            0, 0,            1, 32'h300);
        vecs[15] = mk(0, 0, 0,            0, 0,            1, 32'h304);
        vecs[16] = mk(0, 0, 0,            1, 32'h300,      1, 32'h308);
        // redirect near the top of the address space: wraparound
        vecs[17] = mk(0, 1, 32'hFFFFFFF8, 1, 32'h304,      0, 0);
        vecs[18] = mk(0, 0, 0,            0, 0,            1, 32'hFFFFFFF8);
        vecs[19] = mk(0, 0, 0,            0, 0,            1, 32'hFFFFFFFC);
        vecs[20] = mk(0, 0, 0,            1, 32'hFFFFFFF8, 1, 32'h0);
        vecs[21] = mk(0, 0, 0,            1, 32'hFFFFFFFC, 1, 32'h4);
        vecs[22] = mk(0, 0, 0,            1, 32'h0,        1, 32'h8);

        do_reset(3);
        for (int i = 0; i < 23; i++) begin
            step(vecs[i].stall, vecs[i].pcsrc, vecs[i].target);
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pcd);
            check_req($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
        end

        // redirect with two requests outstanding, 2-cycle memory
        do_reset(3);
        mem_lat = 2;
        step(0, 0, 0);          check_out("redir.c0", 0, 0);      check_req("redir.c0", 1, 32'h0);
        step(0, 0, 0);          check_out("redir.c1", 0, 0);      check_req("redir.c1", 1, 32'h4);
        step(0, 1, 32'h203);    check_out("redir.c2", 0, 0);      check_req("redir.c2", 0, 0);
        step(0, 0, 0);          check_out("redir.c3", 0, 0);      check_req("redir.c3", 1, 32'h200);
        step(0, 0, 0);          check_out("redir.c4", 0, 0);      check_req("redir.c4", 1, 32'h204);
        step(0, 0, 0);          check_out("redir.c5", 0, 0);      check_req("redir.c5", 0, 0);
        step(0, 0, 0);          check_out("redir.c6", 1, 32'h200); check_req("redir.c6", 1, 32'h208);
        step(0, 0, 0);          check_out("redir.c7", 1, 32'h204); check_req("redir.c7", 1, 32'h20C);

        // one-cycle reset with two requests outstanding, 3-cycle memory
        do_reset(3);
        mem_lat = 3;
        step(0, 0, 0);          check_out("mrst.c0", 0, 0);       check_req("mrst.c0", 1, 32'h0);
        step(0, 0, 0);          check_out("mrst.c1", 0, 0);       check_req("mrst.c1", 1, 32'h4);
        do_reset(1);
        step(0, 0, 0);          check_out("mrst.c3", 0, 0);       check_req("mrst.c3", 1, 32'h0);
        step(0, 0, 0);          check_out("mrst.c4", 0, 0);       check_req("mrst.c4", 1, 32'h4);
        step(0, 0, 0);          check_out("mrst.c5", 0, 0);       check_req("mrst.c5", 0, 0);
        step(0, 0, 0);          check_out("mrst.c6", 0, 0);       check_req("mrst.c6", 0, 0);
        step(0, 0, 0);          check_out("mrst.c7", 1, 32'h0);   check_req("mrst.c7", 1, 32'h8);
        step(0, 0, 0);          check_out("mrst.c8", 1, 32'h4);   check_req("mrst.c8", 1, 32'hC);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
